// File: rtl/mc_controller_v2.sv
// Multi-cycle CPU controller: sequences fetch/decode/execute phases and drives
// the datapath strobes and mux selects combinationally from the current state.
module mc_controller_v2 #(
  parameter int OPW         = 5,
  parameter int ALUW        = 3,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            RUN,
  input  logic [OPW-1:0]  OP,
  input  logic [3:0]      ALUFlags,
  input  logic            MemReady,
  output logic            PCWrite,
  output logic            LRWrite,
  output logic            IRWrite,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            MemRead,
  output logic            AdrSrc,
  output logic            RegSrc,
  output logic            ALUSH,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ResultSrc,
  output logic [ALUW-1:0] ALUCtrl,
  output logic [2:0]      ShFunc,
  output logic [3:0]      Flags,
  output logic [3:0]      State,
  output logic            Halted,
  output logic            Illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_LDADR   = 4'd2,
    S_LDWB    = 4'd3,
    S_STR     = 4'd4,
    S_EXECR   = 4'd5,
    S_LDI     = 4'd6,
    S_SHIFT   = 4'd7,
    S_WB      = 4'd8,
    S_BR      = 4'd9,
    S_BL      = 4'd10,
    S_BLR     = 4'd11,
    S_ILLEGAL = 4'd14,
    S_HALT    = 4'd15
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] flags_reg;
  logic       mem_ok;
  logic       rsvd;
  logic       take;
  state_t     decode_target;

  assign mem_ok = MEM_WAIT_EN ? MemReady : 1'b1;

  generate
    if (OPW > 5) begin : g_rsvd
      assign rsvd = |OP[OPW-1:5];
    end else begin : g_no_rsvd
      assign rsvd = 1'b0;
    end
  endgenerate

  // Flags bit order is {N,Z,C,V}; branches test the registered copy only.
  always_comb begin
    take = 1'b0;
    case (OP[4:0])
      5'b10000, 5'b10001: take = 1'b1;
      5'b10100:           take = flags_reg[2];
      5'b10101:           take = ~flags_reg[2];
      5'b10110:           take = flags_reg[1];
      5'b10111:           take = ~flags_reg[1];
      5'b11011:           take = flags_reg[0];
      5'b11100:           take = flags_reg[3];
      5'b11101:           take = ~flags_reg[3];
      default:            take = 1'b0;
    endcase
  end

  always_comb begin
    decode_target = S_ILLEGAL;
    if (!rsvd) begin
      case (OP[4:0])
        5'b11000:                                      decode_target = S_LDADR;
        5'b11010:                                      decode_target = S_STR;
        5'b00000, 5'b00001, 5'b00100, 5'b00101,
        5'b00110, 5'b00111:                            decode_target = S_EXECR;
        5'b11001:                                      decode_target = S_LDI;
        5'b01000, 5'b01001, 5'b01010, 5'b01011,
        5'b01100:                                      decode_target = S_SHIFT;
        5'b10000, 5'b10100, 5'b10101, 5'b10110,
        5'b10111, 5'b11011, 5'b11100, 5'b11101:        decode_target = S_BR;
        5'b10001, 5'b10010:                            decode_target = S_BL;
        5'b11111:                                      decode_target = S_HALT;
        default:                                       decode_target = S_ILLEGAL;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg <= S_FETCH;
      flags_reg <= 4'b0000;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_EXECR) flags_reg <= ALUFlags;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:   if (RUN && mem_ok) state_next = S_DECODE;
      S_DECODE:  state_next = decode_target;
      S_LDADR:   if (mem_ok) state_next = S_LDWB;
      S_LDWB:    state_next = S_FETCH;
      S_STR:     if (mem_ok) state_next = S_FETCH;
      S_EXECR:   state_next = S_WB;
      S_LDI:     state_next = S_WB;
      S_SHIFT:   state_next = S_WB;
      S_WB:      state_next = S_FETCH;
      S_BR:      state_next = S_FETCH;
      S_BL:      state_next = OP[1] ? S_BLR : S_BR;
      S_BLR:     state_next = S_FETCH;
      S_ILLEGAL: state_next = S_ILLEGAL;
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_ILLEGAL;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    LRWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    AdrSrc    = 1'b0;
    RegSrc    = 1'b0;
    ALUSH     = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUCtrl   = '0;
    case (state_reg)
      S_FETCH: begin
        MemRead   = RUN;
        IRWrite   = RUN & mem_ok;
        PCWrite   = RUN & mem_ok;
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        RegSrc    = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
      end
      S_LDADR: begin
        AdrSrc    = 1'b1;
        MemRead   = 1'b1;
        ALUSrcA   = 2'b11;
        ResultSrc = 2'b01;
      end
      S_LDWB: begin
        RegWrite  = 1'b1;
        AdrSrc    = 1'b1;
        RegSrc    = 1'b1;
        ResultSrc = 2'b01;
      end
      S_STR: begin
        AdrSrc   = 1'b1;
        ALUSrcB  = 2'b01;
        MemWrite = mem_ok;
      end
      S_EXECR: begin
        ALUCtrl = OP[ALUW-1:0];
        ALUSrcB = 2'b01;
      end
      S_LDI: begin
        ALUSrcA   = 2'b10;
        ResultSrc = 2'b11;
      end
      S_SHIFT: begin
        ALUSH     = 1'b1;
        ResultSrc = 2'b01;
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegSrc   = 1'b1;
      end
      S_BR: begin
        ResultSrc = 2'b01;
        PCWrite   = take;
      end
      S_BL: begin
        LRWrite = 1'b1;
        ALUSrcA = 2'b10;
      end
      S_BLR: begin
        PCWrite   = 1'b1;
        ResultSrc = 2'b11;
      end
      default: ;
    endcase
  end

  assign ShFunc  = OP[2:0];
  assign Flags   = flags_reg;
  assign State   = state_reg;
  assign Halted  = (state_reg == S_HALT) || (state_reg == S_ILLEGAL);
  assign Illegal = (state_reg == S_ILLEGAL);

endmodule

// File: tb/tb_mc_controller_v2.sv
// Randomised bench for mc_controller_v2: an instruction-path model predicts
// the state walk and strobes; a second no-wait instance gets a directed check.
module tb_mc_controller_v2;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       RUN = 1'b0;
  logic       MemReady = 1'b0;
  logic [7:0] OP = 8'h00;
  logic [3:0] ALUFlags = 4'h0;

  logic pc, lr, ir, rw, mw, mrd, adr, rs, ash, hlt, ill;
  logic [1:0] sa, sb, res;
  logic [2:0] alu, sh;
  logic [3:0] flg, st;

  logic z_pc, z_lr, z_ir, z_rw, z_mw, z_mrd, z_adr, z_rs, z_ash, z_hlt, z_ill;
  logic [1:0] z_sa, z_sb, z_res;
  logic [2:0] z_alu, z_sh;
  logic [3:0] z_flg, z_st;

  mc_controller_v2 #(.OPW(8), .ALUW(3), .MEM_WAIT_EN(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .OP(OP), .ALUFlags(ALUFlags),
    .MemReady(MemReady), .PCWrite(pc), .LRWrite(lr), .IRWrite(ir),
    .RegWrite(rw), .MemWrite(mw), .MemRead(mrd), .AdrSrc(adr), .RegSrc(rs),
    .ALUSH(ash), .ALUSrcA(sa), .ALUSrcB(sb), .ResultSrc(res), .ALUCtrl(alu),
    .ShFunc(sh), .Flags(flg), .State(st), .Halted(hlt), .Illegal(ill)
  );

  mc_controller_v2 #(.OPW(5), .ALUW(3), .MEM_WAIT_EN(1'b0)) dut_nowait (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .OP(OP[4:0]), .ALUFlags(ALUFlags),
    .MemReady(MemReady), .PCWrite(z_pc), .LRWrite(z_lr), .IRWrite(z_ir),
    .RegWrite(z_rw), .MemWrite(z_mw), .MemRead(z_mrd), .AdrSrc(z_adr), .RegSrc(z_rs),
    .ALUSH(z_ash), .ALUSrcA(z_sa), .ALUSrcB(z_sb), .ResultSrc(z_res), .ALUCtrl(z_alu),
    .ShFunc(z_sh), .Flags(z_flg), .State(z_st), .Halted(z_hlt), .Illegal(z_ill)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: instruction-level path of phase numbers.
  int         m_state;
  logic [3:0] m_flags;
  logic [7:0] m_op;
  int         plan[$];
  int         icycles;
  int         stuck;
  logic [4:0] legal [24] = '{5'd24, 5'd26, 5'd0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd7,
                             5'd25, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd16, 5'd20,
                             5'd21, 5'd22, 5'd23, 5'd27, 5'd28, 5'd29, 5'd17, 5'd18};

  task automatic build_plan(input logic [7:0] op);
    int v;
    v = int'(op[4:0]);
    plan.delete();
    if (op[7:5] != 3'b000)                      plan = '{14};
    else if (v == 24)                           plan = '{2, 3};
    else if (v == 26)                           plan = '{4};
    else if (v inside {0, 1, 4, 5, 6, 7})       plan = '{5, 8};
    else if (v == 25)                           plan = '{6, 8};
    else if (v >= 8 && v <= 12)                 plan = '{7, 8};
    else if (v inside {16, 20, 21, 22, 23, 27, 28, 29}) plan = '{9};
    else if (v == 17)                           plan = '{10, 9};
    else if (v == 18)                           plan = '{10, 11};
    else if (v == 31)                           plan = '{15};
    else                                        plan = '{14};
  endtask

  function automatic logic take_fn(input logic [7:0] op, input logic [3:0] f);
    case (op[4:0])
      5'b10000, 5'b10001: return 1'b1;
      5'b10100: return f[2];
      5'b10101: return !f[2];
      5'b10110: return f[1];
      5'b10111: return !f[1];
      5'b11011: return f[0];
      5'b11100: return f[3];
      5'b11101: return !f[3];
      default:  return 1'b0;
    endcase
  endfunction

  // {AdrSrc, RegSrc, ALUSH, ALUSrcA, ALUSrcB, ResultSrc}
  function automatic logic [8:0] mux_exp(input int s);
    case (s)
      0:  return {1'b0, 1'b1, 1'b0, 2'b10, 2'b10, 2'b10};
      1:  return {1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00};
      2:  return {1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 2'b01};
      3:  return {1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01};
      4:  return {1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00};
      5:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00};
      6:  return {1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b11};
      7:  return {1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01};
      8:  return {1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
      9:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01};
      10: return {1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00};
      11: return {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11};
      default: return 9'd0;
    endcase
  endfunction

  task automatic compare_main();
    logic [5:0] exp_str;
    logic e_pc, e_lr, e_ir, e_rw, e_mw, e_mrd;
    e_pc = 0; e_lr = 0; e_ir = 0; e_rw = 0; e_mw = 0; e_mrd = 0;
    case (m_state)
      0:  begin e_mrd = RUN; e_ir = RUN & MemReady; e_pc = RUN & MemReady; end
      2:  e_mrd = 1'b1;
      3:  e_rw = 1'b1;
      4:  e_mw = MemReady;
      8:  e_rw = 1'b1;
      9:  e_pc = take_fn(m_op, m_flags);
      10: e_lr = 1'b1;
      11: e_pc = 1'b1;
      default: ;
    endcase
    exp_str = {e_pc, e_lr, e_ir, e_rw, e_mw, e_mrd};
    check_val("state", 32'(st), 32'(m_state));
    check_val("strobes", 32'({pc, lr, ir, rw, mw, mrd}), 32'(exp_str));
    check_val("muxes", 32'({adr, rs, ash, sa, sb, res}), 32'(mux_exp(m_state)));
    check_val("flags", 32'(flg), 32'(m_flags));
    check_val("halt_ill", 32'({hlt, ill}), 32'({m_state >= 14, m_state == 14}));
    check_val("aluctrl", 32'(alu), (m_state == 5) ? 32'(m_op[2:0]) : 32'd0);
    check_val("shfunc", 32'(sh), 32'(OP[2:0]));
  endtask

  task automatic advance_model();
    icycles++;
    case (m_state)
      0: if (RUN && MemReady) begin
           m_state = 1;
           m_op = OP;
           icycles = 0;
         end
      1: begin
           build_plan(m_op);
           m_state = plan.pop_front();
           if (m_state >= 14)
             $display("instr op=%b -> %s", m_op, (m_state == 15) ? "halt" : "illegal");
         end
      14, 15: stuck++;
      default: begin
        if (!((m_state == 2 || m_state == 4) && !MemReady)) begin
          if (m_state == 5) m_flags = ALUFlags;
          if (plan.size() == 0) begin
            m_state = 0;
            $display("instr op=%b flags=%b cycles=%0d", m_op, m_flags, icycles + 1);
          end else begin
            m_state = plan.pop_front();
          end
        end
      end
    endcase
  endtask

  task automatic do_reset();
    RUN = 1'b0;
    MemReady = 1'($urandom_range(0, 1));
    RESET = 1'b0;
    #1;
    check_val("rst_state", 32'(st), 32'd0);
    check_val("rst_strobes", 32'({pc, lr, ir, rw, mw, mrd}), 32'd0);
    check_val("rst_flags", 32'(flg), 32'd0);
    check_val("rst_halt", 32'({hlt, ill}), 32'd0);
    m_state = 0;
    m_flags = 4'h0;
    plan.delete();
    stuck = 0;
    $display("reset applied");
    @(posedge CLK);
    #2;
    RESET = 1'b1;
  endtask

  task automatic pick_op();
    int r;
    r = $urandom_range(0, 99);
    if (r < 4)       OP = {3'($urandom_range(1, 7)), 5'($urandom)};
    else if (r < 6)  OP = 8'h1f;
    else if (r < 22) OP = {3'b000, 5'($urandom)};
    else             OP = {3'b000, legal[$urandom_range(0, 23)]};
  endtask

  int seq_ld [5] = '{0, 1, 2, 3, 0};
  int seq_st [3] = '{1, 4, 0};

  initial begin
    m_state = 0; m_flags = 0; m_op = 0; icycles = 0; stuck = 0;
    repeat (2) @(posedge CLK);
    #1;
    check_val("init_state", 32'(st), 32'd0);
    check_val("init_strobes", 32'({pc, ir, mrd, mw, rw}), 32'd0);
    check_val("init_flags", 32'(flg), 32'd0);
    #1;
    RESET = 1'b1;

    // No-wait build: memory phases take one cycle even with MemReady low.
    @(posedge CLK);
    #1;
    RUN = 1'b1; MemReady = 1'b0; OP = 8'b000_11000;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check_val("nw_ld_state", 32'(z_st), 32'(seq_ld[i]));
      if (i == 2) check_val("nw_ld_memread", 32'(z_mrd), 32'd1);
      if (i == 3) check_val("nw_ld_regwrite", 32'(z_rw), 32'd1);
      check_val("wait_fetch_state", 32'(st), 32'd0);
      check_val("wait_fetch_strb", 32'({ir, pc, mrd}), 32'b001);
    end
    OP = 8'b000_11010;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_val("nw_st_state", 32'(z_st), 32'(seq_st[i]));
      check_val("nw_st_memwrite", 32'(z_mw), (seq_st[i] == 4) ? 32'd1 : 32'd0);
    end
    @(posedge CLK);
    #1;
    do_reset();

    for (int c = 0; c < 4000; c++) begin
      @(posedge CLK);
      #1;
      if ((m_state >= 14 && stuck > 5) || $urandom_range(0, 59) == 0) begin
        do_reset();
        continue;
      end
      RUN = ($urandom_range(0, 7) != 0);
      MemReady = ($urandom_range(0, 9) < 7);
      ALUFlags = 4'($urandom);
      if (m_state == 0) pick_op();
      @(negedge CLK);
      compare_main();
      advance_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_controller_v2.md
Name: mc_controller_v2

Overview:
- Parametrised successor to the multi-cycle CPU controller; sits between the instruction register and the datapath muxes and enables.
- New relative to the first generation:
  - opcode and ALU-control widths are parameters;
  - full N/Z/C/V condition set;
  - memory wait-state handshake;
  - illegal-opcode trap;
  - explicit halt/status outputs.

Parameters:
- OPW, 5, opcode width; must be ≥5. Bits OP[OPW-1:5] are reserved and must be zero.
- ALUW, 3, width of ALUCtrl; ALUW ≤ 5.
- MEM_WAIT_EN, 1, 1 = honour MemReady; 0 = treat MemReady as always 1.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- RUN  in  1  start/continue enable for FETCH.
- OP  in  OPW  current opcode from the instruction register.
- ALUFlags  in  4  {N,Z,C,V} from the ALU.
- MemReady  in  1  memory access completes this cycle.
- PCWrite, LRWrite, IRWrite, RegWrite, MemWrite, MemRead  out  1 each  write and read strobes.
- AdrSrc, RegSrc, ALUSH  out  1 each  mux selects.
- ALUSrcA, ALUSrcB, ResultSrc  out  2 each  mux selects.
- ALUCtrl  out  ALUW  ALU operation.
- ShFunc  out  3  shifter function = OP[2:0].
- Flags  out  4  registered {N,Z,C,V}.
- State  out  4  current state, for debug.
- Halted  out  1  high in HALT or ILLEGAL.
- Illegal  out  1  high in ILLEGAL.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=FETCH, Flags=0000.
  - All strobes are combinational from state, so they read FETCH values. PCWrite, IRWrite and MemRead are 0 unless RUN=1.
- Default for every output in every state is 0 unless listed below.

States (encoding) and outputs:
- FETCH(0):
  - MemRead=RUN.
  - IRWrite=PCWrite=RUN&MemReady.
  - ALUSrcA=ALUSrcB=ResultSrc=2'b10, RegSrc=1.
  - Stays in FETCH until RUN&MemReady, then goes to DECODE.
- DECODE(1):
  - ALUSrcA=ALUSrcB=2'b10.
  - Next state from OP, below.
- LDADR(2):
  - AdrSrc=1, MemRead=1, ALUSrcA=2'b11, ResultSrc=2'b01.
  - Waits for MemReady, then goes to LDWB.
- LDWB(3):
  - RegWrite=1, AdrSrc=1, RegSrc=1, ResultSrc=2'b01.
  - Next state FETCH.
- STR(4):
  - AdrSrc=1, ALUSrcB=2'b01, MemWrite=MemReady.
  - Waits for MemReady, then goes to FETCH. MemWrite pulses exactly one cycle.
- EXECR(5):
  - ALUCtrl=OP[ALUW-1:0], ALUSrcB=2'b01.
  - Flags<=ALUFlags at exit.
  - Next state WB.
- LDI(6):
  - ALUSrcA=2'b10, ResultSrc=2'b11.
  - Next state WB.
- SHIFT(7):
  - ALUSH=1, ResultSrc=2'b01.
  - Next state WB.
- WB(8):
  - RegWrite=1, RegSrc=1.
  - Next state FETCH.
- BR(9):
  - ResultSrc=2'b01, PCWrite=take.
  - Next state FETCH.
- BL(10):
  - LRWrite=1, ALUSrcA=2'b10.
  - Next state BLR if OP[1]=1, else BR.
- BLR(11):
  - PCWrite=1, ResultSrc=2'b11.
  - Next state FETCH.
- ILLEGAL(14): sticky until reset.
- HALT(15): sticky until reset.

DECODE map (on OP[4:0]; reserved bits nonzero → ILLEGAL):
- 11000 → LDADR.
- 11010 → STR.
- 00000, 00001, 00100, 00101, 00110, 00111 → EXECR.
- 11001 → LDI.
- 01000 to 01100 → SHIFT.
- 10000, 10100 to 10111, 11011, 11100, 11101 → BR.
- 10001, 10010 → BL.
- 11111 → HALT.
- Any other code → ILLEGAL.

Branch condition `take` (uses registered Flags, not live ALUFlags):
- 10000: always.
- 10100: Z.
- 10101: !Z.
- 10110: C.
- 10111: !C.
- 11011: V.
- 11100: N.
- 11101: !N.
- BR entered from BL (OP 10001): take=1.

Other rules:
- Flags change only on exit from EXECR. They hold through wait states and branches.
- With MEM_WAIT_EN=0, FETCH, LDADR and STR each last exactly one cycle.
- A reset asserted mid-instruction aborts immediately. No strobe may glitch high during reset.
- RUN dropping outside FETCH has no effect until the next FETCH.
- Halted = (state==HALT)|(state==ILLEGAL). Illegal = (state==ILLEGAL).

Test Plan:
- Reset then RUN=1, MemReady=1, OP=00101 (ALUFlags=0100) → states 0,1,5,8,0. IRWrite and PCWrite high in cycle 0 only. RegWrite high in WB. Flags=0100 after EXECR.
- OP=11000 with MemReady low 3 cycles in LDADR → LDADR held 4 cycles with MemRead=1. LDWB RegWrite=1 for exactly one cycle. MEM_WAIT_EN=0 build → LDADR lasts 1 cycle.
- Flags=0100 then OP=10101 → PCWrite=0 in BR. Flags=0100 then OP=10100 → PCWrite=1. Flags=1000 then OP=11100 → PCWrite=1.
- OP=10010 → BL(LRWrite=1) then BLR(PCWrite=1) then FETCH. OP=10001 → BL then BR with PCWrite=1.
- OPW=8, OP=8'b0010_0000 → ILLEGAL, Halted=Illegal=1, held with RUN=1 until RESET pulses low → FETCH. OP=11111 → HALT, Illegal=0.
- STR with MemReady low 2 cycles → MemWrite=0, 0, then 1 once. RESET asserted during that wait → state=0 asynchronously, MemWrite=0.
